// File: rtl/multi_tick_gen_pkg.sv
// Shared definitions for the multi-channel tick generator.
// Optional per-channel tick counters are enabled with MULTI_TICK_GEN_TICKCNT_EN.
package multi_tick_gen_pkg;

    // Channel state: free-running, or parked after a one-shot expiry.
    typedef enum logic [0:0] {
        RUN  = 1'b0,
        DONE = 1'b1
    } tick_state_t;

    // Width of the optional per-channel tick counter (wraps 255 -> 0).
    localparam int TICKCNT_W = 8;

endpackage : multi_tick_gen_pkg

// File: rtl/multi_tick_gen_channel.sv
// One programmable tick channel: counter, RUN/DONE state and registered outputs.
// With MULTI_TICK_GEN_TICKCNT_EN defined, the channel also keeps a wrapping tick count.
module tick_channel
    import multi_tick_gen_pkg::*;
#(
    parameter int CNT_W   = 26,
    parameter int SPEED_W = 2
) (
    input  logic                 clk,
    input  logic                 resetN,
    input  logic [CNT_W-1:0]     period,
    input  logic [SPEED_W-1:0]   speed,
    input  logic                 enable,
    input  logic                 oneshot,
    input  logic                 restart,
    output logic                 tick,
    output logic                 duty50,
`ifdef MULTI_TICK_GEN_TICKCNT_EN
    output logic [TICKCNT_W-1:0] tick_cnt,
`endif
    output logic                 done
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] eff_period;
    logic [CNT_W-1:0] count_q, count_d;
    logic             tick_q, tick_d;
    logic             duty_q, duty_d;
    tick_state_t      state_q, state_d;

`ifdef MULTI_TICK_GEN_TICKCNT_EN
    logic [TICKCNT_W-1:0] tick_cnt_q, tick_cnt_d;
`endif

    // The counter runs 0..eff_period, so a tick lands every eff_period+1 enabled cycles.
    assign eff_period = period >> speed;

    // Next-state decode; the if/else order is the priority order of the channel controls.
    always_comb begin
        count_d = count_q;
        tick_d  = 1'b0;
        duty_d  = duty_q;
        state_d = state_q;
`ifdef MULTI_TICK_GEN_TICKCNT_EN
        tick_cnt_d = tick_cnt_q;
`endif
        if (restart) begin
            count_d = '0;
            duty_d  = 1'b0;
            state_d = RUN;
`ifdef MULTI_TICK_GEN_TICKCNT_EN
            tick_cnt_d = '0;
`endif
        end else if (state_q == DONE) begin
            count_d = count_q;
        end else if (!enable) begin
            count_d = count_q;
        end else if (eff_period == '0) begin
            // A zero effective period parks the channel instead of ticking every cycle.
            count_d = '0;
        end else if (count_q >= eff_period) begin
            // >= rather than == so a period lowered below the count fires immediately.
            tick_d  = 1'b1;
            duty_d  = ~duty_q;
            count_d = '0;
            if (oneshot) begin
                state_d = DONE;
            end
`ifdef MULTI_TICK_GEN_TICKCNT_EN
            tick_cnt_d = tick_cnt_q + TICKCNT_W'(1);
`endif
        end else begin
            count_d = count_q + CNT_ONE;
        end
    end

    // Channel registers; reset clears every output at once, independent of the clock.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            count_q <= '0;
            tick_q  <= 1'b0;
            duty_q  <= 1'b0;
            state_q <= RUN;
        end else begin
            count_q <= count_d;
            tick_q  <= tick_d;
            duty_q  <= duty_d;
            state_q <= state_d;
        end
    end

`ifdef MULTI_TICK_GEN_TICKCNT_EN
    // Wrapping count of ticks emitted since reset or the last restart.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            tick_cnt_q <= '0;
        end else begin
            tick_cnt_q <= tick_cnt_d;
        end
    end

    assign tick_cnt = tick_cnt_q;
`endif

    assign tick   = tick_q;
    assign duty50 = duty_q;
    // done comes straight from the state flop, so it rises with the final tick.
    assign done   = (state_q == DONE);

endmodule : tick_channel

// File: rtl/multi_tick_gen.sv
// NUM_CH independent programmable tick channels sharing one clock.
// Define MULTI_TICK_GEN_TICKCNT_EN to expose per-channel 8-bit tick counters.
module multi_tick_gen
    import multi_tick_gen_pkg::*;
#(
    parameter int NUM_CH  = 4,
    parameter int CNT_W   = 26,
    parameter int SPEED_W = 2
) (
    input  logic                          clk,
    input  logic                          resetN,
    input  logic [NUM_CH*CNT_W-1:0]       period,
    input  logic [NUM_CH*SPEED_W-1:0]     speed,
    input  logic [NUM_CH-1:0]             enable,
    input  logic [NUM_CH-1:0]             oneshot,
    input  logic [NUM_CH-1:0]             restart,
    output logic [NUM_CH-1:0]             tick,
    output logic [NUM_CH-1:0]             duty50,
`ifdef MULTI_TICK_GEN_TICKCNT_EN
    output logic [NUM_CH*TICKCNT_W-1:0]   tick_cnt,
`endif
    output logic [NUM_CH-1:0]             done
);

    // One channel per slice of the packed input buses; the top only routes bits.
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        tick_channel #(
            .CNT_W   (CNT_W),
            .SPEED_W (SPEED_W)
        ) u_channel (
            .clk      (clk),
            .resetN   (resetN),
            .period   (period[gi*CNT_W +: CNT_W]),
            .speed    (speed[gi*SPEED_W +: SPEED_W]),
            .enable   (enable[gi]),
            .oneshot  (oneshot[gi]),
            .restart  (restart[gi]),
            .tick     (tick[gi]),
            .duty50   (duty50[gi]),
`ifdef MULTI_TICK_GEN_TICKCNT_EN
            .tick_cnt (tick_cnt[gi*TICKCNT_W +: TICKCNT_W]),
`endif
            .done     (done[gi])
        );
    end

endmodule : multi_tick_gen

// File: tb/tb_multi_tick_gen.sv
// Directed bench for multi_tick_gen (4 channels, CNT_W=26, SPEED_W=2).
// Tick-counter checks are included when MULTI_TICK_GEN_TICKCNT_EN is defined.
module tb_multi_tick_gen;

    localparam int NUM_CH  = 4;
    localparam int CNT_W   = 26;
    localparam int SPEED_W = 2;

    logic                      clk;
    logic                      resetN;
    logic [NUM_CH*CNT_W-1:0]   period;
    logic [NUM_CH*SPEED_W-1:0] speed;
    logic [NUM_CH-1:0]         enable;
    logic [NUM_CH-1:0]         oneshot;
    logic [NUM_CH-1:0]         restart;
    logic [NUM_CH-1:0]         tick;
    logic [NUM_CH-1:0]         duty50;
    logic [NUM_CH-1:0]         done;
`ifdef MULTI_TICK_GEN_TICKCNT_EN
    logic [NUM_CH*8-1:0]       tick_cnt;
`endif

    int errors = 0;
    int checks = 0;
    int ch3_ticks = 0;

    multi_tick_gen #(
        .NUM_CH  (NUM_CH),
        .CNT_W   (CNT_W),
        .SPEED_W (SPEED_W)
    ) dut (
        .clk      (clk),
        .resetN   (resetN),
        .period   (period),
        .speed    (speed),
        .enable   (enable),
        .oneshot  (oneshot),
        .restart  (restart),
        .tick     (tick),
        .duty50   (duty50),
`ifdef MULTI_TICK_GEN_TICKCNT_EN
        .tick_cnt (tick_cnt),
`endif
        .done     (done)
    );

    // 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count ticks on channel 3 (its effective period is always zero in the idle tests).
    always @(negedge clk) if (tick[3]) ch3_ticks++;

    typedef struct {
        string    name;
        logic [3:0] rs;
        int       cycles;
        logic [3:0] exp_tick;
        logic [3:0] exp_duty;
        logic [3:0] exp_done;
    } vec_t;

    vec_t vecs[12];

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic setChannel(input int ch, input int per, input int spd);
        period[ch*CNT_W +: CNT_W]     = CNT_W'(per);
        speed[ch*SPEED_W +: SPEED_W]  = SPEED_W'(spd);
    endtask

    // Restart pulse (if any) lasts only the first cycle of the row.
    task automatic applyStimulus(input vec_t v);
        restart = v.rs;
        step(1);
        restart = '0;
        if (v.cycles > 1) step(v.cycles - 1);
        checkOutput({v.name, " tick"}, 32'(tick),   32'(v.exp_tick));
        checkOutput({v.name, " duty"}, 32'(duty50), 32'(v.exp_duty));
        checkOutput({v.name, " done"}, 32'(done),   32'(v.exp_done));
    endtask

    // Step until channel ch ticks; returns the number of cycles taken (limit on timeout).
    task automatic waitTick(input int ch, input int limit, output int cycles);
        cycles = 0;
        do begin
            step(1);
            cycles++;
        end while (!tick[ch] && cycles < limit);
    endtask

    // Hold reset over a couple of edges and release just after a rising edge.
    task automatic doReset();
        resetN = 1'b0;
        step(2);
        resetN = 1'b1;
    endtask

    initial begin
        int c;
        int pause_bad;
        logic duty_before;

        // Rows are cumulative: time t counts edges since reset release.
        // ch0 eff=20 (tick t%21==0), ch1 eff=5 (t%6==0), ch2 one-shot eff=10, ch3 eff=0.
        vecs[0]  = '{"t5",        4'b0000, 5,  4'b0000, 4'b0000, 4'b0000};
        vecs[1]  = '{"t6",        4'b0000, 1,  4'b0010, 4'b0010, 4'b0000};
        vecs[2]  = '{"t11",       4'b0000, 5,  4'b0100, 4'b0110, 4'b0100};
        vecs[3]  = '{"t12",       4'b0000, 1,  4'b0010, 4'b0100, 4'b0100};
        vecs[4]  = '{"t21",       4'b0000, 9,  4'b0001, 4'b0111, 4'b0100};
        vecs[5]  = '{"t22",       4'b0000, 1,  4'b0000, 4'b0111, 4'b0100};
        vecs[6]  = '{"t24",       4'b0000, 2,  4'b0010, 4'b0101, 4'b0100};
        vecs[7]  = '{"t42",       4'b0000, 18, 4'b0011, 4'b0110, 4'b0100};
        vecs[8]  = '{"t126",      4'b0000, 84, 4'b0011, 4'b0110, 4'b0100};
        vecs[9]  = '{"restart2",  4'b0100, 1,  4'b0000, 4'b0010, 4'b0000};
        vecs[10] = '{"t137",      4'b0000, 10, 4'b0000, 4'b0000, 4'b0000};
        vecs[11] = '{"t138",      4'b0000, 1,  4'b0110, 4'b0110, 4'b0100};

        resetN  = 1'b0;
        period  = '0;
        speed   = '0;
        enable  = '0;
        oneshot = '0;
        restart = '0;
        setChannel(0, 20, 0);
        setChannel(1, 20, 2);
        setChannel(2, 10, 0);
        setChannel(3, 0, 0);
        oneshot = 4'b0100;
        enable  = 4'b1111;
        step(3);
        checkOutput("reset tick", 32'(tick),   32'h0);
        checkOutput("reset duty", 32'(duty50), 32'h0);
        checkOutput("reset done", 32'(done),   32'h0);
        resetN = 1'b1;

        ch3_ticks = 0;
        for (int i = 0; i < 12; i++) applyStimulus(vecs[i]);
        checkOutput("ch3 period0 silent", 32'(ch3_ticks), 32'h0);

        // Pause at count=7 after the first tick; resume needs 14 enabled cycles.
        enable = 4'b0001;
        oneshot = '0;
        setChannel(0, 20, 0);
        doReset();
        step(28);
        duty_before = duty50[0];
        checkOutput("pause duty before", 32'(duty_before), 32'h1);
        enable[0] = 1'b0;
        pause_bad = 0;
        for (int i = 0; i < 50; i++) begin
            step(1);
            if (tick[0] || duty50[0] != duty_before) pause_bad++;
        end
        checkOutput("pause frozen", 32'(pause_bad), 32'h0);
        enable[0] = 1'b1;
        waitTick(0, 100, c);
        checkOutput("resume latency", 32'(c), 32'd14);
        checkOutput("resume duty", 32'(duty50[0]), 32'h0);

        // Restart in the expiry cycle suppresses the tick; zero eff channel stays quiet.
        enable = 4'b1001;
        setChannel(3, 3, 2);
        doReset();
        ch3_ticks = 0;
        step(20);
        checkOutput("pre-expiry tick", 32'(tick[0]), 32'h0);
        restart = 4'b0001;
        step(1);
        restart = '0;
        checkOutput("restart tick", 32'(tick[0]),   32'h0);
        checkOutput("restart duty", 32'(duty50[0]), 32'h0);
        waitTick(0, 60, c);
        checkOutput("post-restart latency", 32'(c), 32'd21);
        step(200);
        checkOutput("eff0 no ticks", 32'(ch3_ticks), 32'h0);

        // Lowering the period below the running count fires on the next cycle.
        enable = 4'b0001;
        doReset();
        step(15);
        setChannel(0, 10, 0);
        step(1);
        checkOutput("lower period fires", 32'(tick[0]), 32'h1);
        setChannel(0, 20, 0);

        // Asynchronous reset mid-count clears outputs without a clock edge.
        enable  = 4'b0101;
        oneshot = 4'b0100;
        doReset();
        step(36);
        checkOutput("pre-reset duty0", 32'(duty50[0]), 32'h1);
        checkOutput("pre-reset done2", 32'(done[2]),   32'h1);
        #2 resetN = 1'b0;
        #1;
        checkOutput("async tick", 32'(tick),   32'h0);
        checkOutput("async duty", 32'(duty50), 32'h0);
        checkOutput("async done", 32'(done),   32'h0);
        step(1);
        resetN = 1'b1;
        waitTick(0, 60, c);
        checkOutput("post-reset latency", 32'(c), 32'd21);

`ifdef MULTI_TICK_GEN_TICKCNT_EN
        // eff=1 ticks every 2 cycles; 256 ticks wrap the counter back to 0.
        enable  = 4'b0001;
        oneshot = '0;
        setChannel(0, 1, 0);
        doReset();
        checkOutput("tick_cnt reset", 32'(tick_cnt[7:0]), 32'h0);
        step(20);
        checkOutput("tick_cnt 10", 32'(tick_cnt[7:0]), 32'd10);
        step(492);
        checkOutput("tick_cnt wrap", 32'(tick_cnt[7:0]), 32'd0);
        step(2);
        checkOutput("tick_cnt after wrap", 32'(tick_cnt[7:0]), 32'd1);
        restart = 4'b0001;
        step(1);
        restart = '0;
        checkOutput("tick_cnt restart", 32'(tick_cnt[7:0]), 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_multi_tick_gen
